multicycle_ctrl: RTL and testbench

//  Multi-cycle main controller for the femtoRV32 core. It sequences each instruction

---
 rtl/multicycle_ctrl_pkg.sv | 45 ++++
 rtl/multicycle_ctrl_mem_wait_timer.sv | 34 +++
 rtl/multicycle_ctrl.sv | 154 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the femtoRV32 multi-cycle controller and ALU control decoder:
// state encodings, opcodes, ALUOp codes, fault causes and the control-bundle payload.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Datapath control bundle driven by the controller each cycle.
  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrcb;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       memtoreg;
    logic       pc_write;
    logic       pc_src;
  } ctrl_t;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory wait timer: counts consecutive stalled cycles while active.
//   clk, rst   : clock, synchronous active-high reset
//   active     : controller is in a memory-waiting state (FETCH/MEM)
//   mem_ready  : memory completes this cycle
//   timeout    : this cycle is the STALL_MAX-th consecutive stall (combinational)
module mem_wait_timer #(
  parameter int unsigned STALL_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  localparam int unsigned CW = $clog2(STALL_MAX + 1);

  logic [CW-1:0] cnt;

  // Leaving FETCH/MEM or a completed access clears the run of stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (active && !mem_ready) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

  // mem_ready on the would-be final stall cycle suppresses the timeout.
  assign timeout = active && !mem_ready && (cnt == CW'(STALL_MAX - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller for femtoRV32: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives ALU op, mux selects and write enables, counts retired instructions and
// detects illegal opcodes and memory timeouts.
//   Inputs : clk, rst (sync, active-high), Inst, mem_ready, zero
//   Outputs: ALUOp, ALUSrcB, IR_write, MemRead, MemWrite, IorD, RegWrite, MemtoReg,
//            PC_write, PC_src (decoded from state), retired, fault, fault_cause
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned STALL_MAX = 16,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      Inst,
  input  logic             mem_ready,
  input  logic             zero,
  output logic [1:0]       ALUOp,
  output logic             ALUSrcB,
  output logic             IR_write,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             PC_write,
  output logic             PC_src,
  output logic [CNT_W-1:0] retired,
  output logic             fault,
  output logic [1:0]       fault_cause
);

  state_t     state, state_n;
  ctrl_t      ctrl;
  logic       retire;
  logic       timeout;
  logic       active;
  logic [6:0] opcode;
  logic       unused_inst;

  assign opcode      = Inst[6:0];
  assign unused_inst = ^Inst[31:7];
  assign active      = (state == ST_FETCH) || (state == ST_MEM);

  mem_wait_timer #(.STALL_MAX(STALL_MAX)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .active    (active),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      ST_FETCH: begin
        if (mem_ready)    state_n = ST_DECODE;
        else if (timeout) state_n = ST_FAULT;
      end
      ST_DECODE: state_n = is_legal(opcode) ? ST_EXEC : ST_FAULT;
      ST_EXEC: begin
        if (opcode == OP_R)           state_n = ST_WB;
        else if (opcode == OP_BRANCH) state_n = ST_FETCH;
        else                          state_n = ST_MEM;
      end
      ST_MEM: begin
        if (mem_ready)    state_n = (opcode == OP_LOAD) ? ST_WB : ST_FETCH;
        else if (timeout) state_n = ST_FAULT;
      end
      ST_WB:    state_n = ST_FETCH;
      ST_FAULT: state_n = ST_FAULT;
      default:  state_n = ST_FAULT;
    endcase
  end

  // Output decode; everything is held low while reset is asserted.
  always_comb begin
    ctrl   = '0;
    retire = 1'b0;
    fault  = 1'b0;
    if (!rst) begin
      case (state)
        ST_FETCH: begin
          ctrl.mem_read = 1'b1;
          ctrl.ir_write = mem_ready;
        end
        ST_EXEC: begin
          if (opcode == OP_R) begin
            ctrl.aluop = ALU_FUNC;
          end else if (opcode == OP_BRANCH) begin
            ctrl.aluop    = ALU_SUB;
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = zero;
            retire        = 1'b1;
          end else begin
            ctrl.aluop   = ALU_ADD;
            ctrl.alusrcb = 1'b1;
          end
        end
        ST_MEM: begin
          ctrl.iord      = 1'b1;
          ctrl.mem_read  = (opcode == OP_LOAD);
          ctrl.mem_write = (opcode == OP_STORE);
          if (mem_ready && (opcode == OP_STORE)) begin
            ctrl.pc_write = 1'b1;
            retire        = 1'b1;
          end
        end
        ST_WB: begin
          ctrl.reg_write = 1'b1;
          ctrl.memtoreg  = (opcode == OP_LOAD);
          ctrl.pc_write  = 1'b1;
          retire         = 1'b1;
        end
        ST_FAULT: fault = 1'b1;
        default: ;
      endcase
    end
  end

  assign ALUOp    = ctrl.aluop;
  assign ALUSrcB  = ctrl.alusrcb;
  assign IR_write = ctrl.ir_write;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign IorD     = ctrl.iord;
  assign RegWrite = ctrl.reg_write;
  assign MemtoReg = ctrl.memtoreg;
  assign PC_write = ctrl.pc_write;
  assign PC_src   = ctrl.pc_src;

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)         retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

  // Cause is captured on entry to FAULT and held until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_cause <= CAUSE_NONE;
    end else if ((state != ST_FAULT) && (state_n == ST_FAULT)) begin
      fault_cause <= (state == ST_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Control bundle bit order:
// {ALUOp[1:0], ALUSrcB, IR_write, MemRead, MemWrite, IorD, RegWrite, MemtoReg, PC_write, PC_src}
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Inst;
  logic        mem_ready;
  logic        zero;
  logic [1:0]  ALUOp;
  logic        ALUSrcB, IR_write, MemRead, MemWrite, IorD;
  logic        RegWrite, MemtoReg, PC_write, PC_src;
  logic [31:0] retired;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [10:0] ctl;

  int vecs = 0;
  int errs = 0;

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_LW  = 32'h00012083;
  localparam logic [31:0] I_SW  = 32'h0020A023;
  localparam logic [31:0] I_BEQ = 32'h00208463;
  localparam logic [31:0] I_BAD = 32'h0000007F;

  localparam logic [31:0] C_NONE      = 32'h000;
  localparam logic [31:0] C_STALL     = 32'h040;
  localparam logic [31:0] C_FETCH     = 32'h0C0;
  localparam logic [31:0] C_EXEC_R    = 32'h400;
  localparam logic [31:0] C_EXEC_LS   = 32'h100;
  localparam logic [31:0] C_BEQ_T     = 32'h203;
  localparam logic [31:0] C_BEQ_NT    = 32'h202;
  localparam logic [31:0] C_MEM_LD    = 32'h050;
  localparam logic [31:0] C_MEM_ST    = 32'h030;
  localparam logic [31:0] C_MEM_ST_OK = 32'h032;
  localparam logic [31:0] C_WB_LD     = 32'h00E;
  localparam logic [31:0] C_WB_R      = 32'h00A;

  multicycle_ctrl #(.STALL_MAX(16), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .Inst        (Inst),
    .mem_ready   (mem_ready),
    .zero        (zero),
    .ALUOp       (ALUOp),
    .ALUSrcB     (ALUSrcB),
    .IR_write    (IR_write),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IorD        (IorD),
    .RegWrite    (RegWrite),
    .MemtoReg    (MemtoReg),
    .PC_write    (PC_write),
    .PC_src      (PC_src),
    .retired     (retired),
    .fault       (fault),
    .fault_cause (fault_cause)
  );

  assign ctl = {ALUOp, ALUSrcB, IR_write, MemRead, MemWrite, IorD,
                RegWrite, MemtoReg, PC_write, PC_src};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1; zero = 1'b0; Inst = 32'h0;

    // Reset state
    tick(); #1;
    chk("rst_ctl", 32'(ctl), C_NONE);
    chk("rst_retired", retired, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_cause", 32'(fault_cause), 32'd0);

    // 1: add, mem_ready=1 -> F,D,E,W
    rst = 1'b0; Inst = I_ADD; #1;
    chk("add_fetch", 32'(ctl), C_FETCH);
    tick(); #1; chk("add_decode", 32'(ctl), C_NONE);
    tick(); #1; chk("add_exec", 32'(ctl), C_EXEC_R);
    tick(); #1; chk("add_wb", 32'(ctl), C_WB_R);
    chk("add_retired_pre", retired, 32'd0);
    tick(); #1; chk("add_retired", retired, 32'd1);

    // 2: lw with 3 stall cycles in MEM
    Inst = I_LW; #1;
    chk("lw_fetch", 32'(ctl), C_FETCH);
    tick(); tick(); #1; chk("lw_exec", 32'(ctl), C_EXEC_LS);
    tick(); mem_ready = 1'b0; #1; chk("lw_mem_stall1", 32'(ctl), C_MEM_LD);
    tick(); #1; chk("lw_mem_stall2", 32'(ctl), C_MEM_LD);
    tick(); #1; chk("lw_mem_stall3", 32'(ctl), C_MEM_LD);
    tick(); mem_ready = 1'b1; #1; chk("lw_mem_done", 32'(ctl), C_MEM_LD);
    tick(); #1; chk("lw_wb", 32'(ctl), C_WB_LD);
    tick(); #1; chk("lw_retired", retired, 32'd2);

    // 3: beq taken then not taken
    Inst = I_BEQ;
    tick(); tick(); zero = 1'b1; #1; chk("beq_taken", 32'(ctl), C_BEQ_T);
    tick(); #1; chk("beq_taken_ret", retired, 32'd3);
    chk("beq_back_fetch", 32'(ctl), C_FETCH);
    tick(); tick(); zero = 1'b0; #1; chk("beq_not_taken", 32'(ctl), C_BEQ_NT);
    tick(); #1; chk("beq_nt_ret", retired, 32'd4);

    // store with immediate completion
    Inst = I_SW;
    tick(); tick(); #1; chk("sw_exec", 32'(ctl), C_EXEC_LS);
    tick(); #1; chk("sw_mem_done", 32'(ctl), C_MEM_ST_OK);
    tick(); #1; chk("sw_retired", retired, 32'd5);

    // 6: reset mid-MEM of a store
    tick(); tick(); tick(); mem_ready = 1'b0; #1;
    chk("sw2_mem_stall", 32'(ctl), C_MEM_ST);
    rst = 1'b1; #1; chk("rst_gate_ctl", 32'(ctl), C_NONE);
    tick(); rst = 1'b0; Inst = I_ADD; #1;
    chk("rst_mid_mem_ctl", 32'(ctl), C_STALL);
    chk("rst_mid_mem_ret", retired, 32'd0);
    chk("rst_mid_mem_fault", 32'(fault), 32'd0);

    // 5 variant: mem_ready rises on the 16th FETCH cycle -> no fault
    for (int i = 2; i <= 15; i++) begin
      tick(); #1; chk("stall15", 32'(ctl), C_STALL);
    end
    tick(); mem_ready = 1'b1; #1; chk("ready16_ctl", 32'(ctl), C_FETCH);
    tick(); #1;
    chk("ready16_nofault", 32'(fault), 32'd0);
    chk("ready16_decode", 32'(ctl), C_NONE);
    tick(); tick(); tick(); #1;
    chk("ready16_retired", retired, 32'd1);

    // 5: 16 stalled FETCH cycles -> timeout fault
    mem_ready = 1'b0; #1; chk("to_stall1", 32'(ctl), C_STALL);
    for (int i = 2; i <= 16; i++) begin
      tick(); #1;
    end
    chk("to_stall16", 32'(ctl), C_STALL);
    chk("to_stall16_nofault", 32'(fault), 32'd0);
    tick(); #1;
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_cause", 32'(fault_cause), 32'd2);
    chk("to_ctl", 32'(ctl), C_NONE);
    chk("to_retired", retired, 32'd1);

    // 4: illegal opcode after reset out of FAULT
    rst = 1'b1; tick(); rst = 1'b0; mem_ready = 1'b1; Inst = I_BAD; #1;
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_cause", 32'(fault_cause), 32'd0);
    chk("bad_fetch", 32'(ctl), C_FETCH);
    tick(); #1; chk("bad_decode", 32'(ctl), C_NONE);
    tick(); #1;
    chk("bad_fault", 32'(fault), 32'd1);
    chk("bad_cause", 32'(fault_cause), 32'd1);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0]; zero = i[1];
      tick(); #1;
      chk("fault_quiet", 32'(ctl), C_NONE);
      chk("fault_sticky", {30'd0, fault_cause}, 32'd1);
    end
    chk("fault_retired", retired, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
